jk_sync_counter: RTL and testbench

- Synchronous up/down counter whose state register is built on JK flip-flop semantics.
- Per-bit J/K excitation is derived from the requested next state, then applied with JK update rules.
- The J/K vectors are exported so they can directly drive a bank of external master-slave JK flip-flops (same clk, same clear).
- Sits directly upstream of the JK flip-flop stage as its excitation generator, and also keeps its own reference copy of the state.

---
 rtl/jk_sync_counter.sv | 109 ++++++++++
 tb/tb_jk_sync_counter.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_sync_counter.sv
// jk_sync_counter: synchronous up/down counter whose state register follows JK
// flip-flop semantics. The per-bit J/K excitation is derived from the requested
// next state. It is exported so it can drive an external bank of JK flip-flops
// that share clk and clear. This block also keeps its own reference copy of the
// state.
//
// Optional build macro JKCNT_SATURATE_EN changes the count behaviour:
//   - The count saturates instead of wrapping.
//   - Loads above MAXVAL are clamped to MAXVAL.
// When the macro is undefined, the count wraps and din is loaded unclamped.
module jk_sync_counter #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned MAXVAL = (1 << WIDTH) - 1
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j_vec,
  output logic [WIDTH-1:0] k_vec,
  output logic             tc
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAXVAL);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] nxt;

  // Requested next count value. Priority order: load first, then count, then hold.
  always_comb begin
    nxt = q_q;
    if (load) begin
`ifdef JKCNT_SATURATE_EN
      nxt = (din > MaxVal) ? MaxVal : din;
`else
      nxt = din;
`endif
    end else if (en) begin
      if (up) begin
        if (q_q >= MaxVal) begin
`ifdef JKCNT_SATURATE_EN
          nxt = MaxVal;
`else
          // A loaded value above MAXVAL also wraps to 0.
          nxt = '0;
`endif
        end else begin
          nxt = q_q + WIDTH'(1);
        end
      end else begin
        if (q_q == '0) begin
`ifdef JKCNT_SATURATE_EN
          nxt = '0;
`else
          nxt = MaxVal;
`endif
        end else begin
          nxt = q_q - WIDTH'(1);
        end
      end
    end
  end

  // J/K excitation. While clear is high, force every bit to reset so that the
  // external JK bank also clears.
  always_comb begin
    j_vec = '0;
    k_vec = '1;
    if (!clear) begin
      j_vec = ~q_q & nxt;
      k_vec = q_q & ~nxt;
    end
  end

  // Apply the JK rules bit by bit. The toggle case (J=K=1) is defensive only;
  // the excitation above never produces it.
  always_comb begin
    q_d = q_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      case ({j_vec[i], k_vec[i]})
        2'b10:   q_d[i] = 1'b1;
        2'b01:   q_d[i] = 1'b0;
        2'b11:   q_d[i] = ~q_q[i];
        default: q_d[i] = q_q[i];
      endcase
    end
  end

  // State register with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Terminal count, combinational on the current state and the enable/direction inputs.
  always_comb begin
    tc = en & ((up & (q_q == MaxVal)) | (~up & (q_q == '0)));
  end

  assign q = q_q;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Directed testbench for jk_sync_counter. It drives one WIDTH=4 full-range
// instance and one decade instance (MAXVAL=9) from the same stimulus.
module tb_jk_sync_counter;

  logic       clk = 1'b0;
  logic       clear, en, up, load;
  logic [3:0] din;
  logic [3:0] q, j_vec, k_vec;
  logic       tc;
  logic [3:0] q9, j9, k9;
  logic       tc9;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  jk_sync_counter #(.WIDTH(4)) dut (
    .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .din(din),
    .q(q), .j_vec(j_vec), .k_vec(k_vec), .tc(tc)
  );

  jk_sync_counter #(.WIDTH(4), .MAXVAL(9)) dut9 (
    .clk(clk), .clear(clear), .en(en), .up(up), .load(load), .din(din),
    .q(q9), .j_vec(j9), .k_vec(k9), .tc(tc9)
  );

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference next-state model written straight from the counting rules.
  function automatic logic [3:0] model_next(input logic [3:0] cq, input logic cen,
                                            input logic cup, input logic cld,
                                            input logic [3:0] cdin, input int mx);
    int v;
    v = cq;
    if (cld) begin
      v = cdin;
`ifdef JKCNT_SATURATE_EN
      if (v > mx) v = mx;
`endif
    end else if (cen && cup) begin
`ifdef JKCNT_SATURATE_EN
      v = (v >= mx) ? mx : v + 1;
`else
      v = (v >= mx) ? 0 : v + 1;
`endif
    end else if (cen) begin
`ifdef JKCNT_SATURATE_EN
      v = (v == 0) ? 0 : v - 1;
`else
      v = (v == 0) ? mx : v - 1;
`endif
    end
    return 4'(v);
  endfunction

  task automatic test_reset();
    clear = 1'b1; en = 1'b1; up = 1'b0; load = 1'b1; din = 4'h7;
    #1;
    tests++;
    if (j_vec !== 4'h0 || k_vec !== 4'hF) begin
      fails++;
      $display("FAIL reset_jk: j=%h k=%h want j=0 k=f", j_vec, k_vec);
    end
    step();
    step();
    tests++;
    if (q !== 4'h0) begin
      fails++;
      $display("FAIL reset_q: got %h want 0", q);
    end
    tests++;
    if (j_vec !== 4'h0 || k_vec !== 4'hF) begin
      fails++;
      $display("FAIL reset_jk_hold: j=%h k=%h want j=0 k=f", j_vec, k_vec);
    end
    tests++;
    if (tc !== 1'b1) begin
      fails++;
      $display("FAIL reset_tc_down: got %b want 1", tc);
    end
    up = 1'b1;
    #1;
    tests++;
    if (tc !== 1'b0) begin
      fails++;
      $display("FAIL reset_tc_up: got %b want 0", tc);
    end
  endtask

  task automatic test_up_count();
    logic [3:0] exp;
    clear = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 18; i++) begin
`ifdef JKCNT_SATURATE_EN
      exp = (i > 15) ? 4'd15 : 4'(i);
`else
      exp = 4'(i % 16);
`endif
      tests++;
      if (q !== exp || tc !== (exp == 4'd15)) begin
        fails++;
        $display("FAIL up_count[%0d]: q=%h tc=%b want q=%h tc=%b", i, q, tc, exp, exp == 4'd15);
      end
      step();
    end
  endtask

  task automatic test_down_wrap();
    logic [3:0] seq [5];
`ifdef JKCNT_SATURATE_EN
    seq = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0};
`else
    seq = '{4'd2, 4'd1, 4'd0, 4'd15, 4'd14};
`endif
    load = 1'b1; din = 4'd2; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (q !== seq[i] || tc !== (seq[i] == 4'd0)) begin
        fails++;
        $display("FAIL down_wrap[%0d]: q=%h tc=%b want q=%h tc=%b", i, q, tc, seq[i],
                 seq[i] == 4'd0);
      end
      if (i == 2) begin
        tests++;
`ifdef JKCNT_SATURATE_EN
        if (j_vec !== 4'h0 || k_vec !== 4'h0) begin
          fails++;
          $display("FAIL down_zero_jk: j=%h k=%h want j=0 k=0", j_vec, k_vec);
        end
`else
        if (j_vec !== 4'hF || k_vec !== 4'h0) begin
          fails++;
          $display("FAIL down_zero_jk: j=%h k=%h want j=f k=0", j_vec, k_vec);
        end
`endif
      end
      step();
    end
  endtask

  task automatic test_load_priority();
    load = 1'b1; din = 4'd5; en = 1'b0;
    step();
    load = 1'b1; din = 4'hA; en = 1'b1; up = 1'b1;
    #1;
    tests++;
    if (j_vec !== 4'hA || k_vec !== 4'h5) begin
      fails++;
      $display("FAIL load_jk: j=%h k=%h want j=a k=5", j_vec, k_vec);
    end
    step();
    tests++;
    if (q !== 4'hA) begin
      fails++;
      $display("FAIL load_priority: got %h want a", q);
    end
    load = 1'b0;
    step();
    tests++;
    if (q !== 4'hB) begin
      fails++;
      $display("FAIL load_then_count: got %h want b", q);
    end
  endtask

  task automatic test_excitation();
    logic [3:0] mq, mn;
    load = 1'b1; din = 4'b0111; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    #1;
    tests++;
    if (j_vec !== 4'b1000 || k_vec !== 4'b0111) begin
      fails++;
      $display("FAIL excite_7: j=%b k=%b want j=1000 k=0111", j_vec, k_vec);
    end
    step();
    tests++;
    if (q !== 4'b1000) begin
      fails++;
      $display("FAIL excite_q: got %b want 1000", q);
    end
    // Random run against the reference model.
    mq = 4'b1000;
    for (int i = 0; i < 200; i++) begin
      clear = ($urandom_range(0, 15) == 0);
      load  = ($urandom_range(0, 7) == 0);
      en    = 1'($urandom);
      up    = 1'($urandom);
      din   = 4'($urandom_range(0, 15));
      #1;
      mn = model_next(mq, en, up, load, din, 15);
      tests++;
      if ((j_vec & k_vec) !== 4'h0) begin
        fails++;
        $display("FAIL rand_jk_overlap[%0d]: j=%h k=%h", i, j_vec, k_vec);
      end
      tests++;
      if (clear ? (j_vec !== 4'h0 || k_vec !== 4'hF)
                : (j_vec !== (~mq & mn) || k_vec !== (mq & ~mn))) begin
        fails++;
        $display("FAIL rand_jk[%0d]: j=%h k=%h q=%h nxt=%h", i, j_vec, k_vec, mq, mn);
      end
      tests++;
      if (tc !== (en & ((up & (mq == 4'd15)) | (~up & (mq == 4'd0))))) begin
        fails++;
        $display("FAIL rand_tc[%0d]: got %b q=%h en=%b up=%b", i, tc, mq, en, up);
      end
      step();
      mq = clear ? 4'h0 : mn;
      tests++;
      if (q !== mq) begin
        fails++;
        $display("FAIL rand_q[%0d]: got %h want %h", i, q, mq);
      end
    end
    clear = 1'b0;
  endtask

  task automatic test_mid_clear();
    load = 1'b1; din = 4'd8; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1; up = 1'b1;
    step();
    tests++;
    if (q !== 4'd9) begin
      fails++;
      $display("FAIL mid_clear_pre: got %h want 9", q);
    end
    clear = 1'b1; load = 1'b1; din = 4'd3;
    step();
    tests++;
    if (q !== 4'd0) begin
      fails++;
      $display("FAIL mid_clear_q: got %h want 0", q);
    end
    clear = 1'b0; load = 1'b0;
    step();
    tests++;
    if (q !== 4'd1) begin
      fails++;
      $display("FAIL mid_clear_resume: got %h want 1", q);
    end
  endtask

  task automatic test_decade();
    logic [3:0] exp;
    clear = 1'b1; load = 1'b0; en = 1'b0;
    step();
    clear = 1'b0; en = 1'b1; up = 1'b1;
    for (int i = 0; i < 11; i++) begin
`ifdef JKCNT_SATURATE_EN
      exp = (i > 9) ? 4'd9 : 4'(i);
`else
      exp = 4'(i % 10);
`endif
      tests++;
      if (q9 !== exp || tc9 !== (exp == 4'd9)) begin
        fails++;
        $display("FAIL decade[%0d]: q=%h tc=%b want q=%h tc=%b", i, q9, tc9, exp, exp == 4'd9);
      end
      if (i == 9) begin
        tests++;
`ifdef JKCNT_SATURATE_EN
        if (j9 !== 4'h0 || k9 !== 4'h0) begin
          fails++;
          $display("FAIL decade_top_jk: j=%h k=%h want j=0 k=0", j9, k9);
        end
`else
        if (j9 !== 4'h0 || k9 !== 4'h9) begin
          fails++;
          $display("FAIL decade_top_jk: j=%h k=%h want j=0 k=9", j9, k9);
        end
`endif
      end
      step();
    end
    load = 1'b1; din = 4'd12;
    step();
    load = 1'b0;
    #1;
`ifdef JKCNT_SATURATE_EN
    exp = 4'd9;
`else
    exp = 4'd12;
`endif
    tests++;
    if (q9 !== exp || tc9 !== (exp == 4'd9)) begin
      fails++;
      $display("FAIL decade_load12: q=%h tc=%b want q=%h tc=%b", q9, tc9, exp, exp == 4'd9);
    end
    step();
`ifdef JKCNT_SATURATE_EN
    exp = 4'd9;
`else
    exp = 4'd0;
`endif
    tests++;
    if (q9 !== exp) begin
      fails++;
      $display("FAIL decade_above_max_up: got %h want %h", q9, exp);
    end
  endtask

  initial begin
    clear = 1'b1; en = 1'b0; up = 1'b0; load = 1'b0; din = 4'h0;
    #2;
    test_reset();
    test_up_count();
    test_down_wrap();
    test_load_priority();
    test_excitation();
    test_mid_clear();
    test_decade();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
